// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute sequencer: decides when the PC advances, picks the
// next-PC source, gates imem/dmem requests and inserts bubbles after redirects.
module pc_sequencer #(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             halt,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_jr,
  input  logic             is_jump,
  input  logic             is_branch,
  input  logic             branch_flag,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    MEMWAIT  = 2'd1,
    REDIRECT = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [2:0]       BUBBLES_C = REDIRECT_BUBBLES[2:0];
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

  state_t           state_r;
  state_t           next_state_s;
  logic [2:0]       bubble_r;
  logic [2:0]       bubble_next_s;
  logic [CNT_W-1:0] stall_r;
  logic             redirect_s;

  // State and bubble counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= FETCH;
      bubble_r <= 3'd0;
    end else begin
      state_r  <= next_state_s;
      bubble_r <= bubble_next_s;
    end
  end

  // Next-state decode and all combinational outputs.
  always_comb begin
    next_state_s  = state_r;
    bubble_next_s = bubble_r;
    redirect_s    = 1'b0;
    pc_en         = 1'b0;
    pc_src        = 2'd0;
    imemREN       = 1'b0;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    flush         = 1'b0;
    halted        = 1'b0;

    case (state_r)
      FETCH: begin
        imemREN = 1'b1;
        if (!ihit) begin
          next_state_s = FETCH;
        end else if (halt) begin
          next_state_s = HALTED;
        end else if (is_load || is_store) begin
          next_state_s = MEMWAIT;
        end else if (is_jr) begin
          pc_en      = 1'b1;
          pc_src     = 2'd1;
          redirect_s = 1'b1;
        end else if (is_jump) begin
          pc_en      = 1'b1;
          pc_src     = 2'd2;
          redirect_s = 1'b1;
        end else if (is_branch) begin
          pc_en      = 1'b1;
          pc_src     = 2'd3;
          redirect_s = branch_flag;
        end else begin
          pc_en  = 1'b1;
          pc_src = 2'd0;
        end

        // A zero bubble count keeps the core fetching straight from the new target.
        if (redirect_s && (REDIRECT_BUBBLES > 32'sd0)) begin
          next_state_s  = REDIRECT;
          bubble_next_s = BUBBLES_C;
        end else begin
          bubble_next_s = bubble_r;
        end
      end

      MEMWAIT: begin
        dmemREN = is_load;
        dmemWEN = is_store & ~is_load;
        if (dhit) begin
          pc_en        = 1'b1;
          pc_src       = 2'd0;
          next_state_s = FETCH;
        end else begin
          next_state_s = MEMWAIT;
        end
      end

      REDIRECT: begin
        flush = 1'b1;
        // Treat a count of 0 like 1 so a corrupted counter can never trap the core here.
        if (bubble_r <= 3'd1) begin
          bubble_next_s = 3'd0;
          next_state_s  = FETCH;
        end else begin
          bubble_next_s = bubble_r - 3'd1;
          next_state_s  = REDIRECT;
        end
      end

      HALTED: begin
        halted       = 1'b1;
        next_state_s = HALTED;
      end

      default: begin
        next_state_s  = FETCH;
        bubble_next_s = 3'd0;
      end
    endcase
  end

  // Saturating stall counter; frozen once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_r <= {CNT_W{1'b0}};
    end else if ((state_r != HALTED) && !pc_en && (stall_r != CNT_MAX_C)) begin
      stall_r <= stall_r + CNT_ONE_C;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_count = stall_r;

  pc_sequencer_chk u_chk (
    .clk      (CLK),
    .rst_n    (nRST),
    .ihit     (ihit),
    .dhit     (dhit),
    .pc_en    (pc_en),
    .pc_src   (pc_src),
    .imem_ren (imemREN),
    .dmem_ren (dmemREN),
    .dmem_wen (dmemWEN),
    .flush    (flush),
    .halted   (halted)
  );

endmodule

// Protocol checker for the sequencer outputs.
module pc_sequencer_chk (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       pc_en,
  input  logic [1:0] pc_src,
  input  logic       imem_ren,
  input  logic       dmem_ren,
  input  logic       dmem_wen,
  input  logic       flush,
  input  logic       halted
);

  // A dmem request may coincide with pc_en only on the cycle it completes.
  a_pc_en_excl: assert property (@(posedge clk) disable iff (!rst_n)
    pc_en |-> (!flush && !halted && (!(dmem_ren || dmem_wen) || dhit)));

  a_pc_src_idle: assert property (@(posedge clk) disable iff (!rst_n)
    !pc_en |-> (pc_src == 2'd0));

  // Each PC update consumes exactly one completed fetch or data access.
  a_pc_en_once: assert property (@(posedge clk) disable iff (!rst_n)
    pc_en |-> ((ihit && imem_ren) || (dhit && (dmem_ren || dmem_wen))));

endmodule
